// File: rtl/rotary_encoder_bank.sv
// Bank of NUM_CH quadrature rotary-encoder decoders with MMIO status/counter registers.
// Define ROTARY_SATURATE_EN to clamp counters at their signed limits instead of wrapping.
module rotary_encoder_bank #(
  parameter int NUM_CH   = 4,
  parameter int CNT_W    = 16,
  parameter int FILT_LEN = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  Read,
  input  logic                  Write,
  input  logic [3:0]            Address,
  input  logic [15:0]           DataIn,
  output logic [15:0]           DataOut,
  output logic                  Ready,
  output logic                  Event,
  input  logic [2*NUM_CH-1:0]   RotaryIn
);

  localparam logic signed [CNT_W-1:0] CNT_MAX = {1'b0, {(CNT_W-1){1'b1}}};
  localparam logic signed [CNT_W-1:0] CNT_MIN = {1'b1, {(CNT_W-1){1'b0}}};
  localparam logic [7:0]              FILT_N  = 8'(FILT_LEN);

  // Read and Write are one-cycle strobes sampled on the rising edge; Ready pulses
  // high exactly the following cycle, and for a read DataOut is valid while Ready is high.
  // A cycle with both strobes is treated as a write.
  logic wr_en;
  logic rd_en;
  assign wr_en = Write;
  assign rd_en = Read & ~Write;

  logic [NUM_CH-1:0]       pend_vec;
  logic [NUM_CH-1:0]       dir_vec;
  logic signed [CNT_W-1:0] cnt_vec [NUM_CH];

  for (genvar c = 0; c < NUM_CH; c++) begin : ch_g
    logic [1:0]              sync1_q;
    logic [1:0]              sync2_q;
    logic [1:0]              cand_q;
    logic [7:0]              fcnt_q;
    logic [1:0]              filt_q;
    logic [1:0]              filt_prev_q;
    logic [1:0]              pos_new;
    logic [1:0]              pos_old;
    logic [1:0]              delta;
    logic                    step;
    logic                    step_up;
    logic                    load;
    logic                    clr;
    logic signed [CNT_W-1:0] cnt_q;
    logic signed [CNT_W-1:0] cnt_next;
    logic                    pend_q;
    logic                    dir_q;

    always_ff @(posedge clock) begin
      if (reset) begin
        sync1_q     <= 2'b00;
        sync2_q     <= 2'b00;
        cand_q      <= 2'b00;
        fcnt_q      <= 8'd0;
        filt_q      <= 2'b00;
        filt_prev_q <= 2'b00;
      end else begin
        sync1_q     <= RotaryIn[2*c +: 2];
        sync2_q     <= sync1_q;
        filt_prev_q <= filt_q;
        if (sync2_q != cand_q) begin
          cand_q <= sync2_q;
          fcnt_q <= 8'd1;
        end else if (fcnt_q != FILT_N) begin
          fcnt_q <= fcnt_q + 8'd1;
        end
        if ((fcnt_q == FILT_N) && (filt_q != cand_q)) filt_q <= cand_q;
      end
    end

    // Gray position 00,01,11,10 -> 0..3; a forward distance of 1 is right, 3 is left.
    assign pos_new = {filt_q[1], filt_q[1] ^ filt_q[0]};
    assign pos_old = {filt_prev_q[1], filt_prev_q[1] ^ filt_prev_q[0]};
    assign delta   = pos_new - pos_old;
    assign step    = (delta == 2'd1) || (delta == 2'd3);
    assign step_up = (delta == 2'd1);

    assign load = wr_en && (Address == 4'(c + 1));
    assign clr  = (wr_en && (Address == 4'd0) && DataIn[c]) ||
                  (rd_en && (Address == 4'(c + 1)));

    always_comb begin
      cnt_next = cnt_q;
`ifdef ROTARY_SATURATE_EN
      if (step_up) begin
        if (cnt_q != CNT_MAX) cnt_next = cnt_q + 1'b1;
      end else begin
        if (cnt_q != CNT_MIN) cnt_next = cnt_q - 1'b1;
      end
`else
      if (step_up) cnt_next = cnt_q + 1'b1;
      else         cnt_next = cnt_q - 1'b1;
`endif
    end

    // A load beats a simultaneous step, but the step still flags pending.
    always_ff @(posedge clock) begin
      if (reset) begin
        cnt_q  <= '0;
        pend_q <= 1'b0;
        dir_q  <= 1'b0;
      end else begin
        if (load)      cnt_q <= DataIn[CNT_W-1:0];
        else if (step) cnt_q <= cnt_next;
        if (step)      pend_q <= 1'b1;
        else if (clr)  pend_q <= 1'b0;
        if (step)      dir_q <= step_up;
      end
    end

    assign pend_vec[c] = pend_q;
    assign dir_vec[c]  = dir_q;
    assign cnt_vec[c]  = cnt_q;
  end

  logic [15:0] rdata;

  always_comb begin
    rdata = '0;
    if (Address == 4'd0) begin
      rdata[NUM_CH-1:0]   = pend_vec;
      rdata[8 +: NUM_CH]  = dir_vec;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (Address == 4'(c + 1)) rdata = 16'(cnt_vec[c]);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      DataOut <= '0;
      Ready   <= 1'b0;
      Event   <= 1'b0;
    end else begin
      Ready <= Read | Write;
      Event <= |pend_vec;
      if (rd_en) DataOut <= rdata;
    end
  end

endmodule
